// File: rtl/call_stack.sv
// call_stack: LIFO for the processor call context (PC, R0-R3 per frame).
// Pushes land one cycle later on data_out; pops expose the popped entry
// combinationally during the pop cycle itself.
// Optional sticky error flags are built only when CALL_STACK_ERR_EN is defined;
// without it overflow/underflow read 0 and clr_err is ignored.
module call_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int SP_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic [SP_W-1:0]  sp,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    // Storage is deliberately not reset; only the pointer defines validity.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [SP_W-1:0]  sp_m1;
    logic [AW-1:0]    top_idx;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             set_ovf;
    logic             set_udf;

    assign sp_m1   = sp_q - SP_W'(1);
    assign top_idx = sp_m1[AW-1:0];
    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SP_W'(DEPTH));
    assign sp      = sp_q;

    // Top-of-stack read is combinational so a pop can be consumed in-cycle.
    always_comb begin
        data_out = '0;
        if (!empty) begin
            data_out = mem_q[top_idx];
        end
    end

    // Decode {push, pop} into pointer update, write strobe and error events.
    always_comb begin
        sp_d    = sp_q;
        wr_en   = 1'b0;
        wr_addr = sp_q[AW-1:0];
        set_ovf = 1'b0;
        set_udf = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (!full) begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + SP_W'(1);
                end else begin
                    set_ovf = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    sp_d = sp_m1;
                end else begin
                    set_udf = 1'b1;
                end
            end
            2'b11: begin
                if (!empty) begin
                    // Replace the top entry in place; legal even when full.
                    wr_en   = 1'b1;
                    wr_addr = top_idx;
                end else begin
                    // Nothing to pop: behave as a plain push, but flag it.
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    sp_d    = SP_W'(1);
                    set_udf = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Memory write; reset leaves the contents untouched and blocks any write.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

`ifdef CALL_STACK_ERR_EN
    logic ovf_q;
    logic ovf_d;
    logic udf_q;
    logic udf_d;

    // Sticky flags: a new error in the same cycle wins over clr_err.
    always_comb begin
        ovf_d = set_ovf | (ovf_q & ~clr_err);
        udf_d = set_udf | (udf_q & ~clr_err);
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    // Flags disabled: illegal operations are still suppressed above, only
    // the reporting is dropped.
    logic unused_err_sig;
    assign unused_err_sig = &{1'b0, clr_err, set_ovf, set_udf};
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Directed testbench for call_stack. Expected flag values follow
// CALL_STACK_ERR_EN so the same bench covers both builds.
module tb_call_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int SP_W  = $clog2(DEPTH) + 1;

`ifdef CALL_STACK_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic [SP_W-1:0]  sp;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int checks   = 0;
    int failures = 0;

    call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .clr_err  (clr_err),
        .data_out (data_out),
        .sp       (sp),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        push = 1'b1; data_in = b;
        tick();
        push = 1'b0;
    endtask

    logic [7:0] seq5 [5];

    initial begin
        seq5[0] = 8'hA1; seq5[1] = 8'hB2; seq5[2] = 8'hC3; seq5[3] = 8'hD4; seq5[4] = 8'hE5;
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = '0;
        tick();
        tick();
        rst = 1'b0;
        $display("reset");
        chk("rst_sp", 32'(sp), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);
        chk("rst_dout", 32'(data_out), 0);

        // Five pushes, each visible one cycle later.
        for (int i = 0; i < 5; i++) begin
            push_byte(seq5[i]);
            $display("push %02h sp=%0d dout=%02h", seq5[i], sp, data_out);
            chk("push_dout", 32'(data_out), 32'(seq5[i]));
        end
        chk("push5_sp", 32'(sp), 5);
        chk("push5_empty", 32'(empty), 0);

        // Five pops, sampling the popped byte during the pop cycle.
        for (int i = 4; i >= 0; i--) begin
            pop = 1'b1;
            #1;
            $display("pop dout=%02h sp=%0d", data_out, sp);
            chk("pop_dout", 32'(data_out), 32'(seq5[i]));
            tick();
        end
        pop = 1'b0;
        chk("pop5_sp", 32'(sp), 0);
        chk("pop5_empty", 32'(empty), 1);
        chk("pop5_dout", 32'(data_out), 0);

        // Fill to capacity, then one push too many.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        $display("fill sp=%0d full=%0b dout=%02h", sp, full, data_out);
        chk("fill_full", 32'(full), 1);
        chk("fill_sp", 32'(sp), 16);
        chk("fill_ovf_pre", 32'(overflow), 0);
        push_byte(8'hFF);
        $display("push ff when full sp=%0d ovf=%0b dout=%02h", sp, overflow, data_out);
        chk("ovf_sp", 32'(sp), 16);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_dout", 32'(data_out), 32'h0F);
        chk("ovf_flag", 32'(overflow), 32'(ERR));

        // Replace top while full: legal, no flag change.
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        push = 1'b1; pop = 1'b1; data_in = 8'hEE;
        tick();
        push = 1'b0; pop = 1'b0;
        $display("push+pop when full sp=%0d dout=%02h", sp, data_out);
        chk("pp_full_sp", 32'(sp), 16);
        chk("pp_full_dout", 32'(data_out), 32'hEE);
        chk("pp_full_ovf", 32'(overflow), 0);
        chk("pp_full_udf", 32'(underflow), 0);

        // Pop from empty, then clear.
        do_reset();
        pop = 1'b1; tick(); pop = 1'b0;
        $display("pop when empty sp=%0d udf=%0b", sp, underflow);
        chk("udf_sp", 32'(sp), 0);
        chk("udf_flag", 32'(underflow), 32'(ERR));
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("udf_clr", 32'(underflow), 0);
        // Error in the same cycle as clr_err: set wins.
        pop = 1'b1; clr_err = 1'b1; tick(); pop = 1'b0; clr_err = 1'b0;
        $display("pop empty with clr_err udf=%0b", underflow);
        chk("udf_set_wins", 32'(underflow), 32'(ERR));

        // Push+pop on empty acts as a push and flags underflow.
        do_reset();
        push = 1'b1; pop = 1'b1; data_in = 8'h5A;
        tick();
        push = 1'b0; pop = 1'b0;
        $display("push+pop when empty sp=%0d dout=%02h udf=%0b", sp, data_out, underflow);
        chk("pp_empty_sp", 32'(sp), 1);
        chk("pp_empty_dout", 32'(data_out), 32'h5A);
        chk("pp_empty_udf", 32'(underflow), 32'(ERR));

        // Replace top with sp=3.
        do_reset();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        chk("rep_pre_sp", 32'(sp), 3);
        chk("rep_pre_dout", 32'(data_out), 32'h33);
        push = 1'b1; pop = 1'b1; data_in = 8'h77;
        tick();
        push = 1'b0; pop = 1'b0;
        $display("replace top sp=%0d dout=%02h", sp, data_out);
        chk("rep_sp", 32'(sp), 3);
        chk("rep_dout", 32'(data_out), 32'h77);
        pop = 1'b1; tick(); pop = 1'b0;
        chk("rep_below", 32'(data_out), 32'h22);

        // Reset together with push discards the frame.
        do_reset();
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        chk("rstpush_pre_sp", 32'(sp), 3);
        rst = 1'b1; push = 1'b1; data_in = 8'h99;
        tick();
        rst = 1'b0; push = 1'b0;
        $display("rst+push sp=%0d empty=%0b", sp, empty);
        chk("rstpush_sp", 32'(sp), 0);
        chk("rstpush_empty", 32'(empty), 1);
        chk("rstpush_ovf", 32'(overflow), 0);
        chk("rstpush_udf", 32'(underflow), 0);
        chk("rstpush_dout", 32'(data_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
